// File: rtl/calc_addsub_scheduler.sv
// Round-robin scheduler that shares one add unit between NREQ calculator requesters.
// Optional WAIT timeout: define CALC_SCHED_TIMEOUT_EN.
module calc_addsub_scheduler #(
  parameter int NREQ    = 2,
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_ci,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  output logic              busy,
  output logic              u_start,
  output logic [W-1:0]      u_a,
  output logic [W-1:0]      u_b,
  output logic              u_ci,
  input  logic [W-1:0]      u_sum,
  input  logic              u_finish,
  output logic              err
);

  // state  | meaning
  // IDLE   | arbitrate; gnt is shown combinationally in the cycle the job is taken
  // ISSUE  | u_start pulse to the shared unit
  // WAIT   | wait for u_finish; first cycle blanked against a stale finish
  // RESP   | one-cycle rsp_valid to the granted requester

  localparam int PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 1) begin : g_bad_param
    $error("calc_addsub_scheduler: NREQ must be 2..4 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] gnt_q;
  logic            blank;

  logic [PW-1:0]   arb_idx;
  logic            arb_hit;
  logic [PW:0]     scan_sum;
  logic [PW-1:0]   scan_idx;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic            sel_ci;
  logic [NREQ-1:0] gnt_c;

  // Scan downward from the farthest offset so the nearest request to rr_ptr wins.
  always_comb begin
    arb_idx  = '0;
    arb_hit  = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_sum = {1'b0, rr_ptr} + (PW+1)'(i);
      if (scan_sum >= (PW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PW+1)'(NREQ);
      end
      scan_idx = scan_sum[PW-1:0];
      if (req[scan_idx]) begin
        arb_idx = scan_idx;
        arb_hit = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_ci = 1'b0;
    gnt_c  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_idx == PW'(i)) begin
        sel_a    = req_a[i*W +: W];
        sel_b    = req_b[i*W +: W];
        sel_ci   = req_ci[i];
        gnt_c[i] = 1'b1;
      end
    end
  end

  assign gnt = (rst && state == S_IDLE && arb_hit) ? gnt_c : '0;

`ifdef CALC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      gnt_q     <= '0;
      blank     <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
      u_start   <= 1'b0;
      u_a       <= '0;
      u_b       <= '0;
      u_ci      <= 1'b0;
`ifdef CALC_SCHED_TIMEOUT_EN
      wait_cnt  <= '0;
      err       <= 1'b0;
`endif
    end else begin
      u_start   <= 1'b0;
      rsp_valid <= '0;
`ifdef CALC_SCHED_TIMEOUT_EN
      err       <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (arb_hit) begin
            u_a     <= sel_a;
            u_b     <= sel_b;
            u_ci    <= sel_ci;
            gnt_q   <= gnt_c;
            rr_ptr  <= (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            u_start <= 1'b1;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          blank <= 1'b1;
`ifdef CALC_SCHED_TIMEOUT_EN
          wait_cnt <= TW'(TIMEOUT - 1);
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          blank <= 1'b0;
          if (!blank && u_finish) begin
            rsp_data  <= u_sum;
            rsp_valid <= gnt_q;
            state     <= S_RESP;
          end
`ifdef CALC_SCHED_TIMEOUT_EN
          else if (wait_cnt == '0) begin
            rsp_data  <= '0;
            rsp_valid <= gnt_q;
            err       <= 1'b1;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
`endif
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_addsub_scheduler.sv
// Self-checking bench for calc_addsub_scheduler with a behavioural unit and round-robin model.
module tb_calc_addsub_scheduler;

  localparam int NREQ = 2;
  localparam int W    = 4;
  localparam int TO   = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ci;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              busy;
  logic              u_start;
  logic [W-1:0]      u_a;
  logic [W-1:0]      u_b;
  logic              u_ci;
  logic [W-1:0]      u_sum;
  logic              u_finish;
  logic              err;

  calc_addsub_scheduler #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .u_start(u_start), .u_a(u_a), .u_b(u_b), .u_ci(u_ci),
    .u_sum(u_sum), .u_finish(u_finish), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Shared-unit model: finish rises unit_delay cycles after it samples start.
  int         unit_delay = 2;
  bit         stale_mode = 1'b0;
  bit         unit_hang  = 1'b0;
  int         ucnt;
  logic       drop_pend;
  logic [W-1:0] ures;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_finish  <= 1'b0;
      u_sum     <= '0;
      ucnt      <= 0;
      drop_pend <= 1'b0;
      ures      <= '0;
    end else begin
      if (drop_pend) begin
        u_finish  <= 1'b0;
        drop_pend <= 1'b0;
      end
      if (u_start) begin
        ures      <= W'(int'(u_a) + int'(u_b) + int'(u_ci));
        ucnt      <= unit_delay;
        drop_pend <= stale_mode;
        if (!stale_mode) u_finish <= 1'b0;
      end else if (ucnt > 0) begin
        ucnt <= ucnt - 1;
        if (ucnt == 1 && !unit_hang) begin
          u_finish <= 1'b1;
          u_sum    <= ures;
        end
      end
    end
  end

  // Requester operands and round-robin reference state.
  logic [W-1:0] opa [NREQ];
  logic [W-1:0] opb [NREQ];
  logic         opc [NREQ];
  int           m_ptr = 0;

  task automatic apply_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
      req_ci[i]       = opc[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = W'($urandom_range(0, (1 << W) - 1));
      opb[i] = W'($urandom_range(0, (1 << W) - 1));
      opc[i] = 1'($urandom_range(0, 1));
    end
    apply_ops();
  endtask

  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    for (int o = 0; o < NREQ; o++) begin
      if (r[(p + o) % NREQ]) return (p + o) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_sum(int k);
    return W'(int'(opa[k]) + int'(opb[k]) + int'(opc[k]));
  endfunction

  function automatic logic [NREQ-1:0] onehot(int k);
    logic [NREQ-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  // Predict the next grant from the model and advance the model pointer.
  function automatic int model_grant(logic [NREQ-1:0] r);
    int k;
    k = rr_pick(r, m_ptr);
    if (k >= 0) m_ptr = (k + 1) % NREQ;
    return k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes one job from the current IDLE cycle (cycle 0); returns at the next IDLE cycle.
  task automatic observe_job(input int limit, output int g_cyc, output logic [NREQ-1:0] g_vec,
                             output int s_cyc, output int r_cyc, output logic [NREQ-1:0] r_vec,
                             output logic [W-1:0] r_dat, output logic r_err);
    g_cyc = -1; s_cyc = -1; r_cyc = -1;
    g_vec = '0; r_vec = '0; r_dat = '0; r_err = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (gnt != '0 && g_cyc < 0) begin g_cyc = c; g_vec = gnt; end
      if (u_start && s_cyc < 0) s_cyc = c;
      if (rsp_valid != '0) begin
        r_cyc = c; r_vec = rsp_valid; r_dat = rsp_data; r_err = err;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    int gc, sc, rc;
    logic [NREQ-1:0] gv, rv;
    logic [W-1:0] rd;
    logic re;
    bit bad;
    int k;
    rst = 1'b0;
    req = 2'b11;
    rand_ops();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({gnt, rsp_valid, rsp_data, busy, u_start, u_a, u_b, u_ci, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b rsp_valid=%b rsp_data=%h busy=%b u_start=%b u_a=%h u_b=%h u_ci=%b err=%b, expected all zero",
               gnt, rsp_valid, rsp_data, busy, u_start, u_a, u_b, u_ci, err);
    end
    tick();
    req = '0;
    tick();
    rst = 1'b1;
    m_ptr = 0;
    tick();
    // Start a job from requester 0, then reset in its first WAIT cycle.
    req = 2'b01;
    k = model_grant(req);
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== '0) begin n_fail++; $display("FAIL reset_mid_gnt: got %b expected 00", gnt); end
    n_cmp++;
    if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_mid_rsp_valid: got %b expected 00", rsp_valid); end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b expected 0", busy); end
    n_cmp++;
    if (u_start !== 1'b0) begin n_fail++; $display("FAIL reset_mid_u_start: got %b expected 0", u_start); end
    tick();
    req = '0;
    tick();
    rst = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) bad = 1'b1;
      tick();
    end
    n_cmp++;
    if (bad) begin n_fail++; $display("FAIL reset_no_stale_rsp: got a response or busy after release, expected none"); end
    // Pointer must be back at 0: simultaneous requests grant requester 0.
    req = 2'b11;
    k = model_grant(req);
    observe_job(40, gc, gv, sc, rc, rv, rd, re);
    req = '0;
    n_cmp++;
    if (gv !== onehot(k)) begin n_fail++; $display("FAIL reset_ptr_grant: got %b expected %b", gv, onehot(k)); end
  endtask

  task automatic test_single_job();
    int gc, sc, rc, k;
    logic [NREQ-1:0] gv, rv;
    logic [W-1:0] rd;
    logic re;
    opa[0] = 4'b0101; opb[0] = 4'b0000; opc[0] = 1'b0;
    apply_ops();
    req = 2'b01;
    k = model_grant(req);
    observe_job(40, gc, gv, sc, rc, rv, rd, re);
    req = '0;
    n_cmp++;
    if (gc !== 0 || gv !== onehot(k)) begin n_fail++; $display("FAIL single_gnt: got %b at cycle %0d, expected %b at cycle 0", gv, gc, onehot(k)); end
    n_cmp++;
    if (sc !== 1) begin n_fail++; $display("FAIL single_start_cycle: got %0d expected 1", sc); end
    n_cmp++;
    if (rc !== 5 || rv !== onehot(k)) begin n_fail++; $display("FAIL single_rsp: got %b at cycle %0d, expected %b at cycle 5", rv, rc, onehot(k)); end
    n_cmp++;
    if (rd !== 4'b0101 || re !== 1'b0) begin n_fail++; $display("FAIL single_data: got %h err=%b expected 5 err=0", rd, re); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", busy); end
    tick();
  endtask

  task automatic test_stale_finish();
    int gc, sc, rc, k;
    logic [NREQ-1:0] gv, rv;
    logic [W-1:0] rd, ex;
    logic re;
    stale_mode = 1'b1;
    opa[1] = 4'b0110; opb[1] = 4'b0011; opc[1] = 1'b1;
    apply_ops();
    req = 2'b10;
    k = model_grant(req);
    ex = exp_sum(k);
    observe_job(40, gc, gv, sc, rc, rv, rd, re);
    req = '0;
    stale_mode = 1'b0;
    n_cmp++;
    if (rc !== 5 || rv !== onehot(k)) begin n_fail++; $display("FAIL stale_rsp: got %b at cycle %0d, expected %b at cycle 5", rv, rc, onehot(k)); end
    n_cmp++;
    if (rd !== ex) begin n_fail++; $display("FAIL stale_data: got %h expected %h", rd, ex); end
  endtask

  task automatic test_round_robin();
    int gc, sc, rc, k;
    logic [NREQ-1:0] gv, rv;
    logic [W-1:0] rd;
    logic re;
    rand_ops();
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      k = model_grant(req);
      observe_job(40, gc, gv, sc, rc, rv, rd, re);
      n_cmp++;
      if (gc !== 0 || gv !== onehot(k)) begin n_fail++; $display("FAIL rr_gnt job %0d: got %b at cycle %0d, expected %b at cycle 0", j, gv, gc, onehot(k)); end
      n_cmp++;
      if (rv !== onehot(k) || rd !== exp_sum(k)) begin n_fail++; $display("FAIL rr_rsp job %0d: got %b/%h expected %b/%h", j, rv, rd, onehot(k), exp_sum(k)); end
    end
    req = '0;
  endtask

  task automatic test_operand_hold();
    int gc, k;
    bit held, done;
    logic [W-1:0] ex, rd;
    opa[0] = 4'b0011;
    opb[0] = W'($urandom_range(0, 15));
    opc[0] = 1'($urandom_range(0, 1));
    apply_ops();
    req = 2'b01;
    k = model_grant(req);
    ex = exp_sum(k);
    gc = -1; held = 1'b1; done = 1'b0; rd = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (gnt != '0 && gc < 0) gc = c;
      if (gc >= 0 && c > gc && u_a !== 4'b0011) held = 1'b0;
      if (rsp_valid != '0) begin done = 1'b1; rd = rsp_data; end
      tick();
      if (gc >= 0 && c == gc) begin
        opa[0] = 4'b1111;
        apply_ops();
      end
    end
    req = '0;
    n_cmp++;
    if (!held || !done) begin n_fail++; $display("FAIL operand_hold: got u_a=%h done=%b, expected u_a=3 held through RESP", u_a, done); end
    n_cmp++;
    if (rd !== ex) begin n_fail++; $display("FAIL operand_hold_data: got %h expected %h", rd, ex); end
  endtask

  task automatic test_random_jobs();
    int gc, sc, rc, k;
    logic [NREQ-1:0] gv, rv;
    logic [W-1:0] rd, ex;
    logic re;
    for (int j = 0; j < 16; j++) begin
      rand_ops();
      unit_delay = $urandom_range(1, 5);
      req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      k = model_grant(req);
      ex = exp_sum(k);
      observe_job(40, gc, gv, sc, rc, rv, rd, re);
      n_cmp++;
      if (gv !== onehot(k) || rv !== onehot(k)) begin n_fail++; $display("FAIL rand_grant job %0d req=%b: got gnt=%b rsp_valid=%b expected %b", j, req, gv, rv, onehot(k)); end
      n_cmp++;
      if (rd !== ex || re !== 1'b0) begin n_fail++; $display("FAIL rand_data job %0d: got %h err=%b expected %h err=0", j, rd, re, ex); end
      n_cmp++;
      if (rc !== 3 + unit_delay) begin n_fail++; $display("FAIL rand_latency job %0d: got %0d expected %0d", j, rc, 3 + unit_delay); end
      if ($urandom_range(0, 1) == 0) req = '0;
    end
    req = '0;
    unit_delay = 2;
    tick();
  endtask

  task automatic test_timeout();
    int k;
`ifdef CALC_SCHED_TIMEOUT_EN
    int gc, sc, rc;
    logic [NREQ-1:0] gv, rv;
    logic [W-1:0] rd;
    logic re;
`else
    bit ok;
`endif
    unit_hang = 1'b1;
    rand_ops();
    req = 2'b01;
    k = model_grant(req);
`ifdef CALC_SCHED_TIMEOUT_EN
    observe_job(60, gc, gv, sc, rc, rv, rd, re);
    req = '0;
    n_cmp++;
    if (rc !== 2 + TO || rv !== onehot(k)) begin n_fail++; $display("FAIL timeout_rsp: got %b at cycle %0d, expected %b at cycle %0d", rv, rc, onehot(k), 2 + TO); end
    n_cmp++;
    if (rd !== '0 || re !== 1'b1) begin n_fail++; $display("FAIL timeout_data_err: got %h err=%b expected 0 err=1", rd, re); end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b err=%b expected 0/0", busy, err); end
    tick();
`else
    ok = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c >= 1 && (busy !== 1'b1 || rsp_valid !== '0 || err !== 1'b0)) ok = 1'b0;
      tick();
      req = '0;
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL no_timeout_hold: got busy=%b rsp_valid=%b err=%b, expected busy held high with no response", busy, rsp_valid, err); end
    rst = 1'b0;
    m_ptr = 0;
    tick();
    rst = 1'b1;
    tick();
`endif
    unit_hang = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req = '0;
    req_a = '0;
    req_b = '0;
    req_ci = '0;
    test_reset();
    test_single_job();
    test_stale_finish();
    test_round_robin();
    test_operand_hold();
    test_random_jobs();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_addsub_scheduler.md
Name: calc_addsub_scheduler

Overview:
- Shares one sign-convert/add unit (4-bit full-adder chain with start/finish handshake) between NREQ calculator requesters, e.g. keypad operand path and display converter.
- Round-robin arbitration, operand capture, start-pulse generation and finish detection.
- Returns the result to the granted requester with a one-cycle response strobe.
- Sits between the calculator control FSM and the shared arithmetic unit.

Parameters:
NREQ, 2, number of requesters (2..4)
W, 4, operand/result width
TIMEOUT, 15, WAIT-state cycle limit (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester request level
req_a  in  NREQ*W  packed operand A, requester i at [i*W +: W]
req_b  in  NREQ*W  packed operand B
req_ci  in  NREQ  per-requester carry-in
gnt  out  NREQ  one-hot grant, high for the single IDLE->ISSUE cycle
rsp_valid  out  NREQ  one-hot, one-cycle response strobe
rsp_data  out  W  result, valid while any rsp_valid bit is high
busy  out  1  high in every state except IDLE
u_start  out  1  one-cycle start pulse to the shared unit
u_a  out  W  registered operand A to the unit
u_b  out  W  registered operand B to the unit
u_ci  out  1  registered carry-in to the unit
u_sum  in  W  unit result
u_finish  in  1  unit finish level; may still be high from the previous operation
err  out  1  timeout strobe (optional feature)

Behaviour:
- Reset values while rst is low: state IDLE, RR pointer 0, all outputs 0.
- Reset is asynchronous assert, synchronous deassert. Reset mid-operation abandons the job silently; no rsp_valid.
- IDLE:
  - If req is nonzero, grant the first set bit searching upward from the RR pointer, wrapping at NREQ.
  - Pulse the gnt bit and capture that requester's a/b/ci into u_a/u_b/u_ci.
  - Set the RR pointer to the granted index + 1 (mod NREQ). Go to ISSUE.
- ISSUE (1 cycle): u_start=1. Go to WAIT.
- WAIT:
  - First cycle is a blanking cycle: u_finish is ignored, so a stale finish from the prior job is never taken.
  - From the second WAIT cycle on, u_finish=1 captures u_sum into rsp_data and goes to RESP.
- RESP (1 cycle): rsp_valid[granted]=1 with rsp_data stable. Go to IDLE.
- Operand stability: u_a/u_b/u_ci are held constant from capture until the IDLE re-entry.
- rsp_data holds its last value until the next capture.
- Requester handshake:
  - Operands are sampled only in the gnt cycle; later changes are ignored.
  - A requester still holding req after its rsp_valid is re-arbitrated normally. Round-robin lets every other pending requester in first.
- Requests arriving during busy wait; nothing is queued beyond the req level.
- Latency with a unit that raises finish 3 cycles after start:
  - req seen in IDLE at cycle 0; gnt cycle 0.
  - u_start cycle 1; finish cycle 4; rsp_valid cycle 5.
  - Throughput is one job per 6 cycles.
- Simultaneous requests with pointer=0: req=2'b11 grants 0 first, then 1 on the next IDLE.

Optional Feature:
CALC_SCHED_TIMEOUT_EN
- Defined: a WAIT cycle counter reset on WAIT entry. When it reaches TIMEOUT without finish, go to RESP with rsp_data=0 and err=1 for that RESP cycle.
- Undefined: WAIT lasts indefinitely, err is tied 0, and no counter logic is built.

Test Plan:
- Reset: rst=0 mid-WAIT (job from requester 0) -> next cycle gnt=0, rsp_valid=0, busy=0, u_start=0. After release, no stale response.
- Single job: req=2'b01, a0=4'b0101, b0=4'b0000, ci0=0; unit model returns 4'b0101 with finish 3 cycles after start -> gnt[0] at cycle 0, u_start at 1, rsp_valid=2'b01 and rsp_data=4'b0101 at cycle 5.
- Stale finish: unit model holds u_finish=1 through the first WAIT cycle, then drops it -> no early response; rsp_valid only after the real finish.
- Round-robin: req=2'b11 held continuously -> grants alternate 0,1,0,1 over 4 jobs. Each rsp_data matches its own requester's operands.
- Operand change after grant: a0 changes from 4'b0011 to 4'b1111 in the cycle after gnt -> u_a stays 4'b0011 until RESP completes.
- Timeout (macro defined, TIMEOUT=15): u_finish held 0 -> rsp_valid and err high 15 WAIT cycles after WAIT entry, rsp_data=0, then IDLE. Without the macro, busy stays high indefinitely.
